// File: rtl/dsp_mul_arbiter_pkg.sv
// Shared constants and types for the shared-multiplier arbiter slice.
`ifndef DSP_MUL_SLICE
// 16-bit operand of requester i from a packed NUM_REQ*16 bus.
`define DSP_MUL_SLICE(bus, i) bus[16*(i)+15 -: 16]
`endif

package dsp_mul_arbiter_pkg;
  localparam int MUL_OPERAND_W = 16;
  localparam int MUL_PRODUCT_W = 32;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ID_W      = 2;

  // Operand pair held in the S1 register.
  typedef struct packed {
    logic signed [MUL_OPERAND_W-1:0] a;
    logic signed [MUL_OPERAND_W-1:0] b;
  } mul_opnd_t;
endpackage

// File: rtl/dsp_16mul.sv
// Combinational signed 16x16 multiplier (single SB_MAC16 tile).
module dsp_16mul
  import dsp_mul_arbiter_pkg::*;
(
  input  logic signed [MUL_OPERAND_W-1:0] a,
  input  logic signed [MUL_OPERAND_W-1:0] b,
  output logic signed [MUL_PRODUCT_W-1:0] p
);
  // Full-precision product, no truncation.
  assign p = a * b;
endmodule

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: one-hot grant, search starts at ptr.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);
  int idx;

  // Walk upward from ptr with wrap; first requester found wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/dsp_mul_arbiter.sv
// Shares one signed 16x16 multiplier between NUM_REQ requesters:
// round-robin grant -> S1 operand register -> dsp_16mul -> S2 output register.
module dsp_mul_arbiter
  import dsp_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W,
  parameter int CNT_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*MUL_OPERAND_W-1:0]   req_a,
  input  logic [NUM_REQ*MUL_OPERAND_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               out_valid,
  output logic signed [MUL_PRODUCT_W-1:0]    out_product,
  output logic [ID_W-1:0]                    out_id,
  input  logic                               out_ready,
  output logic                               busy,
  output logic [CNT_W-1:0]                   done_count
);
  logic [NUM_REQ-1:0][MUL_OPERAND_W-1:0] a_arr, b_arr;
  logic [NUM_REQ-1:0]             gnt;
  logic [ID_W-1:0]                gnt_id, rr_ptr, ptr_nxt;
  logic                           any_req;
  logic                           s1_valid, s1_free, s2_free, s1_adv, xfer;
  logic [ID_W-1:0]                s1_id;
  mul_opnd_t                      s1_op;
  logic signed [MUL_PRODUCT_W-1:0] mul_p;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = `DSP_MUL_SLICE(req_a, g);
    assign b_arr[g] = `DSP_MUL_SLICE(req_b, g);
  end

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any_req)
  );

  // Stall chain: S2 frees when empty or draining; S1 frees when empty or moving.
  assign s2_free   = !out_valid || out_ready;
  assign s1_free   = !s1_valid || s2_free;
  assign s1_adv    = s1_valid && s2_free;
  assign xfer      = any_req && s1_free;
  assign req_ready = s1_free ? gnt : '0;
  assign ptr_nxt   = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
  assign busy      = s1_valid || out_valid;

  dsp_16mul u_mul (
    .a (s1_op.a),
    .b (s1_op.b),
    .p (mul_p)
  );

  // S1: capture granted operands and move the pointer past the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_op.a  <= a_arr[gnt_id];
      s1_op.b  <= b_arr[gnt_id];
      s1_id    <= gnt_id;
      rr_ptr   <= ptr_nxt;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: load product from S1, otherwise clear once handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_id      <= '0;
    end else if (s1_adv) begin
      out_valid   <= 1'b1;
      out_product <= mul_p;
      out_id      <= s1_id;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Count handoffs; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         done_count <= '0;
    else if (out_valid && out_ready) done_count <= done_count + 1'b1;
  end
endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Scoreboard bench for dsp_mul_arbiter: accepted requests push hand-computed
// products; an output monitor pops and compares on every handoff.
module tb_dsp_mul_arbiter;
  localparam int NR = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*16-1:0]  req_a = '0;
  logic [NR*16-1:0]  req_b = '0;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic [31:0]       out_product;
  logic [1:0]        out_id;
  logic              out_ready = 1'b1;
  logic              busy;
  logic [15:0]       done_count;

  dsp_mul_arbiter #(.NUM_REQ(NR), .ID_W(2), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_product (out_product),
    .out_id      (out_id),
    .out_ready   (out_ready),
    .busy        (busy),
    .done_count  (done_count)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0, cyc = 0;
  vec_t mem [NR][8];
  int   head [NR], tail [NR];
  bit   acc [NR];
  exp_t exp_q [$];
  int   grant_log [$], out_log [$], out_cyc [$];
  int   fair_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int   wrap_ord [4] = '{3, 0, 3, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic load(input int i, input int a, input int b, input logic [31:0] p);
    mem[i][tail[i]].a = 16'(a);
    mem[i][tail[i]].b = 16'(b);
    mem[i][tail[i]].p = p;
    tail[i]++;
  endtask

  task automatic clear_tb();
    for (int i = 0; i < NR; i++) begin head[i] = 0; tail[i] = 0; acc[i] = 0; end
    exp_q.delete(); grant_log.delete(); out_log.delete(); out_cyc.delete();
  endtask

  task automatic reset_begin();
    @(posedge clk); #2;
    rst = 1'b1;
    clear_tb();
  endtask

  task automatic reset_end();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NR; i++) if (head[i] < tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy && src_empty()) return;
    end
    n_chk++;
    $display("FAIL drain_timeout: %0d products still pending, busy=%b", exp_q.size(), busy);
  endtask

  always @(posedge clk) cyc++;

  // Requester models: hold valid/operands until the accept is seen.
  initial forever begin
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin head[i]++; acc[i] = 0; end
      if (head[i] < tail[i]) begin
        req_valid[i]      = 1'b1;
        req_a[16*i +: 16] = mem[i][head[i]].a;
        req_b[16*i +: 16] = mem[i][head[i]].b;
      end else begin
        req_valid[i]      = 1'b0;
        req_a[16*i +: 16] = '0;
        req_b[16*i +: 16] = '0;
      end
    end
  end

  // Accept monitor: push expected result for every handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (|req_ready) chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back('{id: 2'(i), p: mem[i][head[i]].p});
          grant_log.push_back(i);
          acc[i] = 1'b1;
        end
      end
    end
  end

  // Output monitor: pop and compare on every handoff.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: product %h id %0d, expected none", out_product, out_id);
      end else begin
        e = exp_q.pop_front();
        chk("out_product", out_product, e.p);
        chk("out_id", 32'(out_id), 32'(e.id));
      end
      out_log.push_back(int'(out_id));
      out_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    clear_tb();
    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_count", 32'(done_count), 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    reset_end();

    // Single request, latency 2
    load(0, 3, -5, 32'hFFFF_FFF1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[0]) seen = 1;
    end
    chk("single_accept_seen", 32'(seen), 1);
    @(negedge clk);
    chk("single_ready_pulse", 32'(req_ready), 0);
    chk("single_lat_k1", 32'(out_valid), 0);
    @(negedge clk);
    chk("single_lat_k2", 32'(out_valid), 1);
    chk("single_product", out_product, 32'hFFFF_FFF1);
    chk("single_id", 32'(out_id), 0);
    @(negedge clk);
    chk("single_done_count", 32'(done_count), 1);
    drain();

    // Fairness: all four held valid
    reset_begin();
    load(0, 1, 10, 32'd10);          load(0, 1, 20, 32'd20);
    load(1, -2, 10, 32'hFFFF_FFEC);  load(1, -2, 20, 32'hFFFF_FFD8);
    load(2, 300, -7, 32'hFFFF_F7CC); load(2, 300, 7, 32'h0000_0834);
    load(3, -1000, -1000, 32'h000F_4240); load(3, 255, 256, 32'h0000_FF00);
    reset_end();
    drain();
    chk("fair_grants", 32'(grant_log.size()), 8);
    chk("fair_outs", 32'(out_log.size()), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("fair_grant_order", 32'(grant_log[k]), 32'(fair_ord[k]));
    for (int k = 0; k < 8 && k < out_log.size(); k++) chk("fair_out_order", 32'(out_log[k]), 32'(fair_ord[k]));
    if (out_cyc.size() == 8) chk("fair_throughput", 32'(out_cyc[7] - out_cyc[0]), 7);
    chk("fair_done_count", 32'(done_count), 8);

    // Backpressure on requester 2 stream
    @(posedge clk); #1 out_ready = 1'b0;
    load(2, 7, -8, 32'hFFFF_FFC8);   load(2, 100, 100, 32'h0000_2710);
    load(2, -300, -300, 32'h0001_5F90); load(2, 12345, 2, 32'h0000_6072);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("bp_out_seen", 32'(seen), 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_hold_product", out_product, 32'hFFFF_FFC8);
      chk("bp_hold_id", 32'(out_id), 2);
      chk("bp_ready_low", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    chk("bp_done_count", 32'(done_count), 12);

    // Corner operands
    load(1, -32768, -32768, 32'h4000_0000);
    load(1, 32767, -32768, 32'hC000_8000);
    load(1, 0, -1, 32'h0000_0000);
    drain();

    // Pointer wrap: 3 then 0 alternate
    reset_begin();
    reset_end();
    load(3, 5, 5, 32'd25); load(3, -6, 6, 32'hFFFF_FFDC);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (grant_log.size() >= 1) seen = 1;
    end
    #1;
    load(0, 9, -9, 32'hFFFF_FFAF); load(0, 1, 1, 32'd1);
    drain();
    chk("wrap_grants", 32'(grant_log.size()), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("wrap_order", 32'(grant_log[k]), 32'(wrap_ord[k]));
    chk("wrap_rr_ptr", 32'(dut.rr_ptr), 1);

    // Reset with S1 and S2 both full
    @(posedge clk); #1 out_ready = 1'b0;
    load(1, 2, 3, 32'd6); load(1, 4, 5, 32'd20); load(1, 6, 7, 32'd42);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("mid_out_seen", 32'(seen), 1);
    chk("mid_s1_full", 32'(req_ready), 0);
    reset_begin();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done_count", 32'(done_count), 0);
    chk("mid_rst_rr_ptr", 32'(dut.rr_ptr), 0);
    out_ready = 1'b1;
    reset_end();
    repeat (8) @(negedge clk);
    chk("mid_idle_busy", 32'(busy), 0);
    load(2, -32768, 1, 32'hFFFF_8000);
    drain();
    chk("mid_post_done_count", 32'(done_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
